// File: rtl/dram_arbiter.sv
// Purpose : two-master round-robin arbiter/sequencer for the single-port data RAM, with ownership lock.
// Latency : grant and RAM strobes are same-cycle; read data, rvalid and err are registered (+1 cycle).
// Backpressure: a requester is stalled (gnt=0) while the other master wins or owns the RAM; it must
//               hold we/addr/wdata until granted.
// Ports   : mX_* master request/response pairs (X=0 CPU, X=1 debug/loader); ram_* RAM port;
//           err flags an out-of-range granted access one cycle after its grant.
module dram_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int WORDS  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rvalid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(WORDS * 4);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;     // master granted most recently (1 = master 1)
    logic              gnt0, gnt1, any_gnt;
    logic              sel_we, in_range;
    logic [ADDR_W-1:0] sel_addr, addr_q;
    logic [DATA_W-1:0] sel_din, din_q;
    logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;
    logic              m0_rvalid_q, m1_rvalid_q, err_q;

    // Arbitration. In every state the next state after a grant (or an idle owner cycle)
    // depends only on the relevant master's lock bit, so it collapses to lock ? OWNx : IDLE.
    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (m0_req && m1_req) begin
                    gnt0 = last_q;
                    gnt1 = ~last_q;
                end else begin
                    gnt0 = m0_req;
                    gnt1 = m1_req;
                end
                if (gnt0)      state_d = m0_lock ? OWN0 : IDLE;
                else if (gnt1) state_d = m1_lock ? OWN1 : IDLE;
            end
            OWN0: begin
                gnt0    = m0_req;
                state_d = m0_lock ? OWN0 : IDLE;
            end
            OWN1: begin
                gnt1    = m1_req;
                state_d = m1_lock ? OWN1 : IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Grants are combinational from req, so they must be gated to stay low during reset.
        if (!rst_n) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt1)      last_d = 1'b1;
        else if (gnt0) last_d = 1'b0;
    end

    assign any_gnt  = gnt0 | gnt1;
    assign sel_we   = gnt1 ? m1_we    : m0_we;
    assign sel_addr = gnt1 ? m1_addr  : m0_addr;
    assign sel_din  = gnt1 ? m1_wdata : m0_wdata;
    assign in_range = sel_addr < LIMIT;

    // Without a grant the RAM port replays the last driven address/data so it never floats.
    assign ram_we   = any_gnt & sel_we & in_range;
    assign ram_addr = any_gnt ? sel_addr : addr_q;
    assign ram_din  = any_gnt ? sel_din  : din_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            addr_q      <= '0;
            din_q       <= '0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            if (any_gnt) begin
                addr_q <= sel_addr;
                din_q  <= sel_din;
            end
            m0_rvalid_q <= gnt0 & ~m0_we;
            m1_rvalid_q <= gnt1 & ~m1_we;
            // Out-of-range reads return zero rather than whatever the RAM aliases to.
            if (gnt0 && !m0_we) m0_rdata_q <= in_range ? ram_dout : '0;
            if (gnt1 && !m1_we) m1_rdata_q <= in_range ? ram_dout : '0;
            err_q       <= any_gnt & ~in_range;
        end
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Purpose : self-checking bench for dram_arbiter with a behavioural RAM and reference model.
// Latency : checks grant/RAM strobes in the request cycle and rvalid/rdata/err one cycle later.
// Backpressure: stimulus holds a master's request fields until the model says it was granted.
module tb_dram_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [31:0] ram_addr, ram_din, ram_dout;
    logic        ram_we, err;

    dram_arbiter #(.DATA_W(32), .ADDR_W(32), .WORDS(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .err(err)
    );

    function automatic logic [31:0] init_val(input int i);
        return (i < 3) ? 32'(i + 1) : 32'h1000 + 32'(i);
    endfunction

    // Behavioural RAM: combinational read, write on rising edge, preloaded while load_en.
    logic        load_en;
    logic [31:0] mem [64];
    assign ram_dout = mem[ram_addr[7:2]];
    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
        end else if (ram_we) begin
            mem[ram_addr[7:2]] <= ram_din;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the RAM, who was served last, memory image, pending responses.
    int          m_owner;      // -1: nobody, else locked master
    int          m_last;
    int          m_g;          // master granted in the current cycle, -1 if none
    logic [31:0] ref_mem [64];
    logic        m_rv [2];
    logic [31:0] m_rd [2];
    logic        m_err;
    logic [31:0] m_addr_hold, m_din_hold;

    task automatic model_reset();
        m_owner = -1; m_last = 1; m_g = -1;
        m_rv[0] = 1'b0; m_rv[1] = 1'b0;
        m_rd[0] = '0;   m_rd[1] = '0;
        m_err = 1'b0; m_addr_hold = '0; m_din_hold = '0;
    endtask

    typedef struct {
        logic        r0, w0, l0;
        logic [31:0] a0, d0;
        logic        r1, w1, l1;
        logic [31:0] a1, d1;
        bit          tab;              // table expectations below are meaningful
        logic        eg0, eg1, ewe;
        logic        erv0, erv1, eerr;
        logic [31:0] erd0, erd1;
    } vec_t;

    function automatic vec_t V(input logic r0, w0, l0, input logic [31:0] a0, d0,
                               input logic r1, w1, l1, input logic [31:0] a1, d1,
                               input logic [2:0] g, input logic [2:0] rv,
                               input logic [31:0] erd0, erd1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
        v.tab = 1'b1;
        {v.eg0, v.eg1, v.ewe}    = g;
        {v.erv0, v.erv1, v.eerr} = rv;
        v.erd0 = erd0; v.erd1 = erd1;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        m0_req = v.r0; m0_we = v.w0; m0_lock = v.l0; m0_addr = v.a0; m0_wdata = v.d0;
        m1_req = v.r1; m1_we = v.w1; m1_lock = v.l1; m1_addr = v.a1; m1_wdata = v.d1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_gnt0"}, m0_gnt, 1'b0);
        chk1({tag, "_gnt1"}, m1_gnt, 1'b0);
        chk1({tag, "_ram_we"}, ram_we, 1'b0);
        chk({tag, "_ram_addr"}, ram_addr, 32'h0);
        chk({tag, "_ram_din"}, ram_din, 32'h0);
        chk1({tag, "_rvalid0"}, m0_rvalid, 1'b0);
        chk1({tag, "_rvalid1"}, m1_rvalid, 1'b0);
        chk({tag, "_rdata0"}, m0_rdata, 32'h0);
        chk({tag, "_rdata1"}, m1_rdata, 32'h0);
        chk1({tag, "_err"}, err, 1'b0);
    endtask

    // One clock cycle: starts just after a falling edge, ends on the next falling edge.
    task automatic step(input vec_t v);
        logic        r [2], w [2], l [2];
        logic [31:0] a [2], d [2];
        logic        inr, exp_we;
        int          g;
        apply(v);
        r[0] = v.r0; w[0] = v.w0; l[0] = v.l0; a[0] = v.a0; d[0] = v.d0;
        r[1] = v.r1; w[1] = v.w1; l[1] = v.l1; a[1] = v.a1; d[1] = v.d1;
        if (m_owner >= 0)         g = r[m_owner] ? m_owner : -1;
        else if (r[0] && r[1])    g = 1 - m_last;
        else if (r[0])            g = 0;
        else if (r[1])            g = 1;
        else                      g = -1;
        m_g = g;
        exp_we = (g >= 0) && w[g] && (a[g] < 32'd256);
        #1;
        chk1("gnt0", m0_gnt, g == 0);
        chk1("gnt1", m1_gnt, g == 1);
        chk1("ram_we", ram_we, exp_we);
        chk("ram_addr", ram_addr, (g >= 0) ? a[g] : m_addr_hold);
        chk("ram_din", ram_din, (g >= 0) ? d[g] : m_din_hold);
        if (v.tab) begin
            chk1("tab_gnt0", m0_gnt, v.eg0);
            chk1("tab_gnt1", m1_gnt, v.eg1);
            chk1("tab_ram_we", ram_we, v.ewe);
        end
        @(posedge clk);
        m_rv[0] = 1'b0; m_rv[1] = 1'b0; m_err = 1'b0;
        if (g >= 0) begin
            inr = a[g] < 32'd256;
            m_last = g;
            m_owner = l[g] ? g : -1;
            m_addr_hold = a[g]; m_din_hold = d[g];
            m_err = ~inr;
            if (w[g]) begin
                if (inr) ref_mem[a[g][7:2]] = d[g];
            end else begin
                m_rv[g] = 1'b1;
                m_rd[g] = inr ? ref_mem[a[g][7:2]] : 32'h0;
            end
        end else if (m_owner >= 0 && !l[m_owner]) begin
            m_owner = -1;
        end
        #1;
        chk1("rvalid0", m0_rvalid, m_rv[0]);
        chk1("rvalid1", m1_rvalid, m_rv[1]);
        chk("rdata0", m0_rdata, m_rd[0]);
        chk("rdata1", m1_rdata, m_rd[1]);
        chk1("err", err, m_err);
        if (v.tab) begin
            chk1("tab_rvalid0", m0_rvalid, v.erv0);
            chk1("tab_rvalid1", m1_rvalid, v.erv1);
            chk1("tab_err", err, v.eerr);
            if (v.erv0) chk("tab_rdata0", m0_rdata, v.erd0);
            if (v.erv1) chk("tab_rdata1", m1_rdata, v.erd1);
        end
        @(negedge clk);
    endtask

    vec_t tbl [$];
    vec_t idle_v;

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        idle_v = V(0,0,0,0,0, 0,0,0,0,0, 3'b000, 3'b000, 0, 0);

        // Reset with both masters requesting: everything must stay quiet.
        rst_n = 1'b0; load_en = 1'b1;
        apply(V(1,1,1,32'h44,32'h77, 1,0,1,32'h8,32'h66, 3'b000, 3'b000, 0, 0));
        #2;
        chk_all_zero("reset");
        @(posedge clk); #1;
        chk_all_zero("reset_held");
        @(negedge clk);
        load_en = 1'b0; rst_n = 1'b1;
        model_reset();

        // {gnt0,gnt1,ram_we} and {rvalid0,rvalid1,err} as seen for that row's access.
        // Alternation with both requesting; master 0 wins the first tie after reset.
        tbl.push_back(V(1,1,0,32'h10,32'hA0, 1,1,0,32'h40,32'hB0, 3'b101, 3'b000, 0, 0));
        tbl.push_back(V(1,1,0,32'h14,32'hA1, 1,1,0,32'h40,32'hB0, 3'b011, 3'b000, 0, 0));
        tbl.push_back(V(1,1,0,32'h14,32'hA1, 1,1,0,32'h44,32'hB1, 3'b101, 3'b000, 0, 0));
        tbl.push_back(V(1,1,0,32'h18,32'hA2, 1,1,0,32'h44,32'hB1, 3'b011, 3'b000, 0, 0));
        tbl.push_back(V(1,1,0,32'h18,32'hA2, 1,1,0,32'h48,32'hB2, 3'b101, 3'b000, 0, 0));
        tbl.push_back(V(1,1,0,32'h1C,32'hA3, 1,1,0,32'h48,32'hB2, 3'b011, 3'b000, 0, 0));
        tbl.push_back(V(1,1,0,32'h1C,32'hA3, 1,1,0,32'h4C,32'hB3, 3'b101, 3'b000, 0, 0));
        tbl.push_back(V(0,0,0,0,0,           1,1,0,32'h4C,32'hB3, 3'b011, 3'b000, 0, 0));
        tbl.push_back(V(1,0,0,32'h1C,0,      0,0,0,0,0,           3'b100, 3'b100, 32'hA3, 0));
        // Master 1 locks for three reads while master 0 waits, then master 0 gets in.
        tbl.push_back(V(1,0,0,32'h34,0, 1,0,1,32'h0,0, 3'b010, 3'b010, 0, 32'd1));
        tbl.push_back(V(1,0,0,32'h34,0, 1,0,1,32'h4,0, 3'b010, 3'b010, 0, 32'd2));
        tbl.push_back(V(1,0,0,32'h34,0, 1,0,0,32'h8,0, 3'b010, 3'b010, 0, 32'd3));
        tbl.push_back(V(1,0,0,32'h34,0, 0,0,0,0,0,     3'b100, 3'b100, 32'h100D, 0));
        // Write then immediate read-back.
        tbl.push_back(V(1,1,0,32'h8,32'hDEADBEEF, 0,0,0,0,0, 3'b101, 3'b000, 0, 0));
        tbl.push_back(V(1,0,0,32'h8,0,            0,0,0,0,0, 3'b100, 3'b100, 32'hDEADBEEF, 0));
        // Out of range: granted, write suppressed, read returns zero, err both times.
        tbl.push_back(V(1,1,0,32'h100,32'h55, 0,0,0,0,0, 3'b100, 3'b001, 0, 0));
        tbl.push_back(V(1,0,0,32'h100,0,      0,0,0,0,0, 3'b100, 3'b101, 32'h0, 0));
        // Misaligned read ignores the low address bits.
        tbl.push_back(V(0,0,0,0,0, 1,1,0,32'h4,32'h12345678, 3'b011, 3'b000, 0, 0));
        tbl.push_back(V(0,0,0,0,0, 1,0,0,32'h6,0,            3'b010, 3'b010, 0, 32'h12345678));
        tbl.push_back(idle_v);
        // Highest legal word, read back through a misaligned address.
        tbl.push_back(V(1,1,0,32'hFC,32'hCAFE, 0,0,0,0,0, 3'b101, 3'b000, 0, 0));
        tbl.push_back(V(1,0,0,32'hFF,0,        0,0,0,0,0, 3'b100, 3'b100, 32'hCAFE, 0));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Master 0 locks, then idles while holding ownership; master 1 is shut out.
        step(V(1,1,1,32'h20,32'h99, 0,0,0,0,0,    3'b101, 3'b000, 0, 0));
        step(V(0,0,1,32'h20,32'h99, 1,0,0,32'h4,0, 3'b000, 3'b000, 0, 0));
        step(V(0,0,1,32'h20,32'h99, 1,0,0,32'h4,0, 3'b000, 3'b000, 0, 0));
        // Reset mid-lock, asynchronously in the middle of the cycle.
        #2; rst_n = 1'b0; #1;
        chk_all_zero("midlock_rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(V(0,0,0,0,0, 1,0,0,32'h4,0, 3'b010, 3'b010, 0, 32'h12345678));

        // A granted read cut off by reset must not produce an rvalid.
        apply(V(0,0,0,0,0, 1,0,0,32'h0,0, 3'b000, 3'b000, 0, 0));
        #2;
        chk1("pre_rst_gnt1", m1_gnt, 1'b1);
        rst_n = 1'b0; #1;
        chk1("rst_gnt1", m1_gnt, 1'b0);
        @(posedge clk); #1;
        chk1("rst_drop_rvalid1", m1_rvalid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Randomized traffic; a master keeps its request fields until granted.
        begin
            vec_t        v;
            logic        rr [2], rw [2], rl [2];
            logic [31:0] ra [2], rd [2];
            for (int k = 0; k < 2; k++) begin
                rr[k] = 1'b0; rw[k] = 1'b0; rl[k] = 1'b0; ra[k] = '0; rd[k] = '0;
            end
            v = idle_v;
            v.tab = 1'b0;
            for (int c = 0; c < 600; c++) begin
                for (int k = 0; k < 2; k++) begin
                    if (!(rr[k] && m_g != k) || c == 0) begin
                        rr[k] = ($urandom_range(0, 3) != 0);
                        rw[k] = 1'($urandom_range(0, 1));
                        rl[k] = ($urandom_range(0, 4) == 0);
                        ra[k] = ($urandom_range(0, 9) == 0) ? 32'h100 + $urandom_range(0, 255)
                                                             : 32'($urandom_range(0, 255));
                        rd[k] = $urandom;
                    end
                end
                v.r0 = rr[0]; v.w0 = rw[0]; v.l0 = rl[0]; v.a0 = ra[0]; v.d0 = rd[0];
                v.r1 = rr[1]; v.w1 = rw[1]; v.l1 = rl[1]; v.a1 = ra[1]; v.d1 = rd[1];
                step(v);
            end
        end

        // Final memory image must match the model.
        for (int i = 0; i < 64; i++) chk("mem_image", mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
Two-master arbiter and sequencer for the 64-word data RAM (32-bit words, combinational read, write on rising clk edge, word index = addr>>2). Master 0 is the CPU memory stage and master 1 is the debug/loader port. The block multiplexes address, write data and write enable onto the single RAM port using round-robin arbitration with optional ownership locking. It registers read data back to the granted master with a one-cycle valid strobe.

Parameters:
DATA_W, 32, data word width
ADDR_W, 32, byte address width from masters
WORDS, 64, RAM depth in words; legal byte addresses are 0 .. WORDS*4-1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
m0_req  in  1  master 0 access request; holds we/addr/wdata stable until granted
m0_we  in  1  master 0 write (1) / read (0)
m0_lock  in  1  master 0 keeps ownership after current grant
m0_addr  in  ADDR_W  master 0 byte address
m0_wdata  in  DATA_W  master 0 write data
m0_gnt  out  1  master 0 access accepted this cycle
m0_rdata  out  DATA_W  master 0 read data, valid with m0_rvalid
m0_rvalid  out  1  one-cycle strobe, read data for master 0
m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rdata, m1_rvalid  same as master 0, for master 1
ram_addr  out  ADDR_W  byte address to RAM
ram_din  out  DATA_W  write data to RAM
ram_we  out  1  RAM write enable
ram_dout  in  DATA_W  RAM combinational read data
err  out  1  one-cycle strobe, granted access was out of range

Behaviour:
- Reset (rst_n low, async) forces the following, and all are held while rst_n is low:
  - state=IDLE, last=1 (master 0 wins the first tie)
  - all gnt/rvalid/err=0, rdata=0
  - ram_we=0, ram_addr=0, ram_din=0
- FSM states: IDLE, OWN0, OWN1.
- Arbitration is combinational from state and the two req inputs. At most one gnt per cycle.
- IDLE:
  - Only one req high: grant it.
  - Both high: grant the master not equal to last.
  - On a grant: last<=granted master; next state is OWNx if mX_lock=1, else IDLE.
- OWNx:
  - Only master x can be granted, even if the other master requests.
  - If mX_req=1: grant x. Stay in OWNx while mX_lock=1; go to IDLE when mX_lock=0 on that grant.
  - If mX_req=0 and mX_lock=0: go to IDLE with no grant this cycle.
  - If mX_req=0 and mX_lock=1: stay in OWNx, idle cycle.
- Grant cycle datapath:
  - ram_addr, ram_din and the write strobe come from the granted master.
  - ram_we = gnt & we & in_range.
  - The write commits at the end of the grant cycle.
- No grant:
  - ram_we=0.
  - ram_addr/ram_din hold their last driven values. No X propagation.
- in_range = (addr < WORDS*4). Address bits [1:0] are ignored (word access only).
- Read latency:
  - Granted read in cycle N: mX_rdata<=ram_dout (or 0 if out of range) at the edge ending N.
  - mX_rvalid=1 in cycle N+1 only.
  - mX_rdata holds its value until the next read for that master.
- Out-of-range access:
  - Still granted; write suppressed; read returns 0.
  - err=1 in cycle N+1 for both reads and writes.
- Throughput: one access per cycle.
  - Back-to-back grants to the same master are allowed when the other master is idle or this master holds the lock.
  - A write to address A in cycle N followed by a read of A in cycle N+1 returns the new data.
- Masters must not change we/addr/wdata while req=1 and gnt=0. Behaviour otherwise is undefined, but the block must still issue at most one RAM write per cycle.
- Reset asserted mid-lock: ownership is released immediately and any pending rvalid is dropped.

Test Plan:
- Reset then m0 write addr 0x8 data 0xDEADBEEF, next cycle m0 read 0x8 -> m0_gnt each cycle; ram_we=1 in first cycle only; m0_rvalid=1 one cycle later with m0_rdata=0xDEADBEEF.
- m0_req and m1_req both held high, lock=0, 4 accesses each -> grants alternate m0,m1,m0,m1…; m0 wins first after reset; no cycle has both gnt high.
- m1 asserts lock with 3 reads of 0x0,0x4,0x8 (preloaded 1,2,3) while m0_req=1 -> m1 granted 3 consecutive cycles with rdata 1,2,3; m0 granted in the cycle after m1 drops lock.
- m0 write to 0x100 (out of range) data 0x55 -> gnt=1, ram_we=0, err=1 next cycle; read of 0x100 -> rdata=0, err=1.
- Locked m0 holds ownership with req=0 for 2 cycles, then rst_n pulsed low mid-lock -> all outputs 0 immediately; after release, m1 request granted in the first cycle.
- Misaligned m1 read of 0x6 after writing 0x12345678 to 0x4 -> m1_rdata=0x12345678.
